branch_btb: RTL and testbench

//  Fetch-side branch predictor and the initiator end of the BRU compare path.
//  A direct-mapped BTB with 2-bit saturating counters predicts taken/target
//  for each fetch PC one cycle after lookup. The decode/execute stages carry

---
 rtl/branch_btb_if.sv | 35 +++
 rtl/branch_btb.sv | 145 ++++++++++++++
 tb/tb_branch_btb.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/branch_btb_if.sv
// Fetch/predict/update bundle between the fetch unit, BRU and the BTB.
// Latency: none; this is wiring only.
// Backpressure: none; every request is accepted in the cycle it is driven.
interface branch_btb_if;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        fetch_cancel;
  logic        btb_clear;

  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;

  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_jr;

  // Fetch/BRU side: issues lookups and training updates.
  modport master (
    output fetch_valid, fetch_pc, fetch_cancel, btb_clear,
    output upd_valid, upd_pc, upd_taken, upd_target, upd_jr,
    input  pred_valid, pred_pc, pred_hit, pred_taken, pred_target
  );

  // BTB side: answers lookups and absorbs updates.
  modport slave (
    input  fetch_valid, fetch_pc, fetch_cancel, btb_clear,
    input  upd_valid, upd_pc, upd_taken, upd_target, upd_jr,
    output pred_valid, pred_pc, pred_hit, pred_taken, pred_target
  );
endinterface

// File: rtl/branch_btb.sv
// Direct-mapped BTB with 2-bit saturating counters, trained by BRU outcomes.
// Latency: prediction 1 cycle after lookup; update visible to a same-cycle lookup.
// Backpressure: none; lookups and updates are accepted every cycle.
module branch_btb #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int TAG_W   = 26
) (
  input logic         clk,
  input logic         resetn,
  branch_btb_if.slave bus
);

  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] jr_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];

  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic             wr_en;
  logic [1:0]       new_ctr;
  logic             new_jr;
  logic [31:0]      new_tgt;

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             byp;
  logic             l_valid;
  logic [TAG_W-1:0] l_tag;
  logic [1:0]       l_ctr;
  logic             l_jr;
  logic [31:0]      l_tgt;
  logic             l_hit;
  logic             l_taken;
  logic [31:0]      l_target;
  logic [31:0]      seq_pc;

  logic        pred_valid_q;
  logic [31:0] pred_pc_q;
  logic        pred_hit_q;
  logic        pred_taken_q;
  logic [31:0] pred_target_q;

  // Byte-offset bits of the update PC play no part in indexing or tagging.
  logic unused_bits;
  assign unused_bits = ^bus.upd_pc[1:0];

  assign upd_idx = bus.upd_pc[IDX_W+1:2];
  assign upd_tag = bus.upd_pc[31:IDX_W+2];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // Training: allocate on a taken miss, otherwise walk the counter of a hit.
  // A clear in the same cycle suppresses the write entirely.
  always_comb begin
    wr_en   = 1'b0;
    new_ctr = ctr_q[upd_idx];
    new_jr  = jr_q[upd_idx];
    new_tgt = tgt_q[upd_idx];
    if (bus.upd_valid && !bus.btb_clear) begin
      if (upd_hit) begin
        wr_en = 1'b1;
        if (bus.upd_taken) begin
          new_ctr = (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'd1;
          new_jr  = bus.upd_jr;
          new_tgt = bus.upd_target;
        end else begin
          new_ctr = (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'd1;
        end
      end else if (bus.upd_taken) begin
        wr_en   = 1'b1;
        new_ctr = 2'b10;
        new_jr  = bus.upd_jr;
        new_tgt = bus.upd_target;
      end
    end
  end

  assign f_idx  = bus.fetch_pc[IDX_W+1:2];
  assign f_tag  = bus.fetch_pc[31:IDX_W+2];
  assign seq_pc = {bus.fetch_pc[31:2] + 30'd1, 2'b00};

  // Lookup reads the post-update entry when the update hits the same index.
  always_comb begin
    byp     = wr_en && (upd_idx == f_idx);
    l_valid = byp ? 1'b1    : valid_q[f_idx];
    l_tag   = byp ? upd_tag : tag_q[f_idx];
    l_ctr   = byp ? new_ctr : ctr_q[f_idx];
    l_jr    = byp ? new_jr  : jr_q[f_idx];
    l_tgt   = byp ? new_tgt : tgt_q[f_idx];
    l_hit   = !bus.btb_clear && l_valid && (l_tag == f_tag);
    l_taken = l_hit && (l_jr || l_ctr[1]);
    l_target = l_taken ? l_tgt : seq_pc;
  end

  // Valid bits are the only reset state in the table.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
    end else if (bus.btb_clear) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[upd_idx] <= 1'b1;
    end
  end

  // Entry payload; meaningless until the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[upd_idx] <= upd_tag;
      ctr_q[upd_idx] <= new_ctr;
      jr_q[upd_idx]  <= new_jr;
      tgt_q[upd_idx] <= new_tgt;
    end
  end

  // Prediction register; payload only moves when a lookup is launched.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pred_valid_q  <= 1'b0;
      pred_pc_q     <= '0;
      pred_hit_q    <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
    end else begin
      pred_valid_q <= bus.fetch_valid;
      if (bus.fetch_valid) begin
        pred_pc_q     <= bus.fetch_pc;
        pred_hit_q    <= l_hit;
        pred_taken_q  <= l_taken;
        pred_target_q <= l_target;
      end
    end
  end

  // A cancel in the cycle the prediction is presented kills it.
  assign bus.pred_valid  = pred_valid_q && !bus.fetch_cancel;
  assign bus.pred_pc     = pred_pc_q;
  assign bus.pred_hit    = pred_hit_q;
  assign bus.pred_taken  = pred_taken_q;
  assign bus.pred_target = pred_target_q;

endmodule

// File: tb/tb_branch_btb.sv
// Directed bench for branch_btb: table of single-cycle vectors plus cancel/reset sequences.
// Latency: checks each prediction on the falling edge after its lookup edge.
// Backpressure: none exercised; the DUT accepts every cycle.
module tb_branch_btb;

  logic clk;
  logic resetn;
  branch_btb_if bus();

  branch_btb #(.ENTRIES(16), .IDX_W(4), .TAG_W(26)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        ujr;
    logic        fv;
    logic [31:0] fpc;
    logic        clr;
    logic        ehit;
    logic        etaken;
    logic [31:0] etgt;
  } vec_t;

  vec_t vecs[$];
  int   n_chk;
  int   n_fail;

  localparam logic [31:0] B = 32'h1c00_0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic uv, input logic [31:0] upc, input logic ut,
                     input logic [31:0] utgt, input logic ujr, input logic fv,
                     input logic [31:0] fpc, input logic clr, input logic ehit,
                     input logic etaken, input logic [31:0] etgt);
    vec_t v;
    v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.ujr = ujr;
    v.fv = fv; v.fpc = fpc; v.clr = clr;
    v.ehit = ehit; v.etaken = etaken; v.etgt = etgt;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    bus.fetch_valid  = 1'b0;
    bus.fetch_pc     = '0;
    bus.fetch_cancel = 1'b0;
    bus.btb_clear    = 1'b0;
    bus.upd_valid    = 1'b0;
    bus.upd_pc       = '0;
    bus.upd_taken    = 1'b0;
    bus.upd_target   = '0;
    bus.upd_jr       = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " pred_valid"},  {31'd0, bus.pred_valid}, 32'd0);
    chk({tag, " pred_hit"},    {31'd0, bus.pred_hit},   32'd0);
    chk({tag, " pred_taken"},  {31'd0, bus.pred_taken}, 32'd0);
    chk({tag, " pred_pc"},     bus.pred_pc,             32'd0);
    chk({tag, " pred_target"}, bus.pred_target,         32'd0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    idle_inputs();
    resetn = 1'b0;

    //   uv  upc         ut  utgt         jr  fv  fpc           clr hit tk  tgt
    add(0, 0,           0, 0,           0, 1, B,            0, 0, 0, B + 32'h4);     // cold miss
    add(1, B + 32'h10,  1, B + 32'h40,  0, 0, 0,            0, 0, 0, 0);             // allocate ctr=10
    add(0, 0,           0, 0,           0, 1, B + 32'h10,   0, 1, 1, B + 32'h40);    // hit weakly taken
    add(1, B + 32'h10,  0, 0,           0, 0, 0,            0, 0, 0, 0);             // ctr 01
    add(1, B + 32'h10,  0, 0,           0, 1, B + 32'h10,   0, 1, 0, B + 32'h14);    // ctr 00, bypassed
    add(1, B + 32'h10,  0, 0,           0, 1, B + 32'h10,   0, 1, 0, B + 32'h14);    // 00 holds
    add(1, B + 32'h10,  1, B + 32'h40,  0, 1, B + 32'h10,   0, 1, 0, B + 32'h14);    // ctr 01
    add(1, B + 32'h10,  1, B + 32'h40,  0, 1, B + 32'h10,   0, 1, 1, B + 32'h40);    // ctr 10
    add(1, B + 32'h10,  1, B + 32'h40,  0, 0, 0,            0, 0, 0, 0);             // ctr 11
    add(1, B + 32'h10,  1, B + 32'h40,  0, 0, 0,            0, 0, 0, 0);             // 11 holds
    add(1, B + 32'h10,  0, 0,           0, 1, B + 32'h10,   0, 1, 1, B + 32'h40);    // ctr 10
    add(0, 0,           0, 0,           0, 1, B + 32'h410,  0, 0, 0, B + 32'h414);   // alias misses
    add(1, B + 32'h410, 1, B + 32'h500, 0, 1, B + 32'h10,   0, 0, 0, B + 32'h14);    // alias replaces
    add(0, 0,           0, 0,           0, 1, B + 32'h410,  0, 1, 1, B + 32'h500);   // new owner hits
    add(1, B + 32'h30,  0, 0,           0, 0, 0,            0, 0, 0, 0);             // nt miss: no alloc
    add(0, 0,           0, 0,           0, 1, B + 32'h30,   0, 0, 0, B + 32'h34);
    add(1, B + 32'h20,  1, B + 32'h1000,1, 1, B + 32'h20,   0, 1, 1, B + 32'h1000);  // JIRL bypass
    add(1, B + 32'h20,  0, 0,           0, 0, 0,            0, 0, 0, 0);             // ctr 01, jr kept
    add(1, B + 32'h20,  0, 0,           0, 1, B + 32'h20,   0, 1, 1, B + 32'h1000);  // ctr 00, jr taken
    add(0, 0,           0, 0,           0, 1, 32'hffff_fffc,0, 0, 0, 32'h0);         // target wraps
    add(0, 0,           0, 0,           0, 1, B + 32'h413,  0, 1, 1, B + 32'h500);   // pc[1:0] ignored
    add(0, 0,           0, 0,           0, 1, B + 32'h410,  1, 0, 0, B + 32'h414);   // clear + lookup
    add(0, 0,           0, 0,           0, 1, B + 32'h20,   0, 0, 0, B + 32'h24);    // cleared
    add(1, B + 32'h50,  1, B + 32'h80,  0, 0, 0,            1, 0, 0, 0);             // clear beats upd
    add(0, 0,           0, 0,           0, 1, B + 32'h50,   0, 0, 0, B + 32'h54);

    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      bus.upd_valid   = vecs[i].uv;
      bus.upd_pc      = vecs[i].upc;
      bus.upd_taken   = vecs[i].ut;
      bus.upd_target  = vecs[i].utgt;
      bus.upd_jr      = vecs[i].ujr;
      bus.fetch_valid = vecs[i].fv;
      bus.fetch_pc    = vecs[i].fpc;
      bus.btb_clear   = vecs[i].clr;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d pred_valid", i), {31'd0, bus.pred_valid}, {31'd0, vecs[i].fv});
      if (vecs[i].fv) begin
        chk($sformatf("v%0d pred_pc", i),     bus.pred_pc, vecs[i].fpc);
        chk($sformatf("v%0d pred_hit", i),    {31'd0, bus.pred_hit},   {31'd0, vecs[i].ehit});
        chk($sformatf("v%0d pred_taken", i),  {31'd0, bus.pred_taken}, {31'd0, vecs[i].etaken});
        chk($sformatf("v%0d pred_target", i), bus.pred_target, vecs[i].etgt);
      end
    end
    idle_inputs();

    // Cancel: launch a lookup, then kill it in the cycle it is presented.
    bus.fetch_valid = 1'b1;
    bus.fetch_pc    = B + 32'h10;
    @(posedge clk);
    #1;
    bus.fetch_valid  = 1'b0;
    bus.fetch_cancel = 1'b1;
    @(negedge clk);
    chk("cancel pred_valid", {31'd0, bus.pred_valid}, 32'd0);
    chk("cancel pred_hit",   {31'd0, bus.pred_hit},   32'd0);
    bus.fetch_cancel = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post-cancel pred_valid", {31'd0, bus.pred_valid}, 32'd0);

    // Reset mid-lookup with a taken update in flight: nothing survives.
    bus.fetch_valid = 1'b1;
    bus.fetch_pc    = B + 32'h60;
    @(posedge clk);
    @(negedge clk);
    chk("pre-reset pred_valid", {31'd0, bus.pred_valid}, 32'd1);
    bus.upd_valid   = 1'b1;
    bus.upd_pc      = B + 32'h60;
    bus.upd_taken   = 1'b1;
    bus.upd_target  = B + 32'h90;
    bus.fetch_pc    = B + 32'h60;
    #2;
    resetn = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("heldreset");
    idle_inputs();
    resetn = 1'b1;
    @(negedge clk);
    bus.fetch_valid = 1'b1;
    bus.fetch_pc    = B + 32'h60;
    @(posedge clk);
    @(negedge clk);
    chk("after-reset pred_valid",  {31'd0, bus.pred_valid}, 32'd1);
    chk("after-reset pred_hit",    {31'd0, bus.pred_hit},   32'd0);
    chk("after-reset pred_target", bus.pred_target, B + 32'h64);
    bus.fetch_pc = B + 32'h410;
    @(posedge clk);
    @(negedge clk);
    chk("after-reset alias hit", {31'd0, bus.pred_hit}, 32'd0);
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
